sincos: RTL and testbench
=========================

# sincos

Iterative CORDIC rotation-mode engine. It takes a signed angle in degrees and returns its cosine and sine. It is the inverse companion of the combinational vectoring-mode `arctan` block and uses the same Q8.24-degree angle format and the same arctan(2^-i) constant set. One micro-rotation is performed per clock, with a start/busy/done handshake, so that downstream blocks can regenerate a vector from an angle that `arctan` produced.

## Interface
- `ITER`, default 32: number of CORDIC iterations. Legal range is 1..38.
- `clk`  input  1: sole clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request a conversion. Sampled only in IDLE.
- `ang`  input  32: signed angle, Q8.24 degrees (1.0° = 0x0100_0000). Legal range is [-128°, +128°).
- `busy`  output  1: high while a conversion is in progress (LOAD-accepted through DONE).
- `done`  output  1: one-cycle pulse when `cos_out`/`sin_out` update.
- `cos_out`  output  32: signed cosine, Q8.24 (1.0 = 0x0100_0000).
- `sin_out`  output  32: signed sine, Q8.24.

## Operation
- **Internal datapath**
  - `x`, `y`, `z` are 40-bit signed, Q8.32.
  - Constant `atan[i]` = round(atan(2^-i)·180/π·2^32), for i = 0..37.
  - Gain constant K = 0x00_9B74_EDA8 (0.6072529350 · 2^32).
- **States:** IDLE, RUN, DONE.
- **IDLE with `start`=1:** load `z = {ang, 8'h00}` and `cnt = 0`, then go to RUN. Quadrant pre-rotation is applied at load:
  - `ang` > +90°: `z -= 90°`, `x = 0`, `y = +K`.
  - `ang` < -90°: `z += 90°`, `x = 0`, `y = -K`.
  - Otherwise: `x = K`, `y = 0`. Exactly ±90° takes this path.
- **RUN, iteration `i = cnt`:**
  - `d = +1` if `z >= 0`, else `d = -1`.
  - `x ← x − d·(y >>> i)`.
  - `y ← y + d·(x >>> i)`, using the pre-update `x`.
  - `z ← z − d·atan[i]`.
  - Shifts are arithmetic. Additions are 40-bit wrap; no overflow is possible for legal inputs.
  - `cnt` increments each RUN cycle. After iteration `ITER−1`, go to DONE.
- **DONE:** register `cos_out = x[39:8]` and `sin_out = y[39:8]` (rounding per Configuration), pulse `done`, and return to IDLE.
- **Output holding:** `cos_out` and `sin_out` hold their value until the next DONE.
- **`start` while busy:** ignored, not queued.
- **`ang` sampling:** `ang` is sampled only on the accepting edge; changes during RUN have no effect.

## Timing
- **Reset values:** IDLE, `busy=0`, `done=0`, `cos_out=0`, `sin_out=0`, `cnt=0`.
- **Latency:**
  - `start` sampled high at edge E0 → `busy` high after E0.
  - Iterations run on edges E1..E_ITER.
  - `done` and the new outputs are valid after edge E_ITER+1.
  - `busy` falls after edge E_ITER+2, together with `done`.
- **Throughput:** a new `start` can be accepted on the edge on which `done` deasserts, giving one conversion per ITER+2 cycles.
- **Reset mid-operation:** an asynchronous `rst_n` low immediately returns all state and outputs to the reset values. The partial result is discarded.
- **Simultaneous events:** `start` high during DONE is ignored. The caller must hold or re-assert `start` in IDLE.
- **Accuracy:** with `ITER=32`, |error| ≤ 8 LSB (Q8.24) on each output across the legal range.

## Configuration
- Macro: `SINCOS_ROUND_EN`.
  - **Defined:** outputs are rounded, i.e. `(x + 40'd128) >>> 8` and likewise for `y`, then take bits [31:0].
  - **Undefined:** plain truncation `x[39:8]`, `y[39:8]`.
- Latency and handshake are identical in both builds.

## Test plan
- **Reset:** assert `rst_n=0` mid-RUN.
  - Required: `busy`, `done`, `cos_out`, `sin_out` all 0 immediately.
  - Required: the next `start` completes normally.
- **`ang`=0x0000_0000:**
  - `cos_out` ≈ 0x0100_0000, `sin_out` ≈ 0x0000_0000 (±8 LSB).
  - `done` exactly 33 cycles after the `start` edge with `ITER=32`.
- **`ang`=0x1E00_0000 (30°):**
  - `cos_out` ≈ 0x00DD_B3D7, `sin_out` ≈ 0x0080_0000 (±8 LSB).
- **`ang`=0x7800_0000 (120°, pre-rotation path):**
  - `cos_out` ≈ 0xFF80_0000, `sin_out` ≈ 0x00DD_B3D7 (±8 LSB).
- **`ang`=0xA600_0000 (−90°, boundary):**
  - `cos_out` ≈ 0x0000_0000, `sin_out` ≈ 0xFF00_0000 (±8 LSB).
- **Handshake:** pulse `start` again with a different `ang` at cycle 10 of RUN.
  - Required: it is ignored; the result matches the first angle.
  - Required: `done` pulses once, for one cycle, and outputs hold until the next conversion.

Source files
------------

// File: rtl/sincos.sv
// sincos: iterative CORDIC rotation-mode engine.
//
// Takes a signed Q8.24-degree angle and produces its cosine and sine in Q8.24.
// One micro-rotation per clock. The handshake is start / busy / done.
//
// Parameters
//   ITER     number of CORDIC iterations, 1..38 (default 32)
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, sampled only while idle
//   ang      signed angle, Q8.24 degrees, sampled on the accepting edge
//   busy     high from the accepting edge through the done pulse
//   done     one-cycle pulse when cos_out / sin_out update
//   cos_out  signed cosine, Q8.24, held until the next done
//   sin_out  signed sine, Q8.24, held until the next done
//
// Build option
//   SINCOS_ROUND_EN  when defined, the outputs are rounded to nearest.
//                    Otherwise they are truncated. Timing is the same in both builds.
module sincos #(
    parameter int unsigned ITER = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ang,
    output logic        busy,
    output logic        done,
    output logic [31:0] cos_out,
    output logic [31:0] sin_out
);

    // Elaboration-time arctangent table. Each value is round(atan(2^-i) in degrees * 2^32).
    // It is derived from atan series evaluated in 96-bit fixed point, with pi taken from Machin.
    localparam int unsigned FracW = 96;
    typedef logic [191:0] wide_t;

    // atan(1/n) * 2^FracW by the alternating Taylor series (n >= 2).
    function automatic wide_t atan_inv(input wide_t n);
        wide_t p;
        wide_t sum;
        wide_t term;
        p   = (wide_t'(1) << FracW) / n;
        sum = '0;
        for (int k = 0; k < 64; k++) begin
            term = p / wide_t'(2 * k + 1);
            if ((k % 2) == 0) sum = sum + term;
            else              sum = sum - term;
            p = p / (n * n);
        end
        return sum;
    endfunction

    localparam wide_t QuarterPi = (wide_t'(4) * atan_inv(wide_t'(5))) - atan_inv(wide_t'(239));

    function automatic logic [39:0] atan_const(input int unsigned i);
        wide_t a;
        wide_t num;
        wide_t res;
        if (i == 0) begin
            res = wide_t'(45) << 32;
        end else begin
            // degrees = 45 * atan(2^-i) / atan(1)
            a   = atan_inv(wide_t'(1) << i);
            num = a * (wide_t'(45) << 32);
            res = (num * wide_t'(2) + QuarterPi) / (QuarterPi * wide_t'(2));
        end
        return res[39:0];
    endfunction

    logic [39:0] atan_tab [38];

    for (genvar g = 0; g < 38; g++) begin : g_atan
        localparam logic [39:0] AtanVal = atan_const(g);
        assign atan_tab[g] = AtanVal;
    end

    localparam logic signed [39:0] GainK   = 40'sh00_9B74_EDA8;
    localparam logic signed [39:0] Deg90   = 40'sh5A_0000_0000;
    localparam logic        [5:0]  LastCnt = 6'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q;
    logic        [5:0]  cnt_q;
    logic signed [39:0] x_q, y_q, z_q;

    // Load values, including the quadrant pre-rotation for |ang| > 90 degrees.
    logic signed [31:0] ang_s;
    logic signed [39:0] z_ang;
    logic signed [39:0] x_load, y_load, z_load;

    assign ang_s = $signed(ang);
    assign z_ang = $signed({ang, 8'h00});

    always_comb begin
        x_load = GainK;
        y_load = '0;
        z_load = z_ang;
        if (ang_s > 32'sh5A00_0000) begin
            x_load = '0;
            y_load = GainK;
            z_load = z_ang - Deg90;
        end else if (ang_s < 32'shA600_0000) begin
            x_load = '0;
            y_load = -GainK;
            z_load = z_ang + Deg90;
        end
    end

    // One micro-rotation. Both shifts use the pre-update x and y.
    logic signed [39:0] x_sh, y_sh, atan_i;
    logic signed [39:0] x_nxt, y_nxt, z_nxt;

    assign x_sh   = x_q >>> cnt_q;
    assign y_sh   = y_q >>> cnt_q;
    assign atan_i = $signed(atan_tab[cnt_q]);

    always_comb begin
        if (!z_q[39]) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_i;
        end else begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_i;
        end
    end

    // Q8.32 -> Q8.24 output conversion
    logic [31:0] cos_res, sin_res;

`ifdef SINCOS_ROUND_EN
    assign cos_res = 32'((x_q + 40'sd128) >>> 8);
    assign sin_res = 32'((y_q + 40'sd128) >>> 8);
`else
    assign cos_res = x_q[39:8];
    assign sin_res = y_q[39:8];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    busy <= start;
                    if (start) begin
                        x_q     <= x_load;
                        y_q     <= y_load;
                        z_q     <= z_load;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    x_q   <= x_nxt;
                    y_q   <= y_nxt;
                    z_q   <= z_nxt;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == LastCnt) state_q <= StDone;
                end
                StDone: begin
                    // busy remains high here. It drops on the next edge, together with done.
                    cos_out <= cos_res;
                    sin_out <= sin_res;
                    done    <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sincos.sv
module tb_sincos;

    localparam int unsigned ITER = 32;
    localparam int          TOL  = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] ang;
    logic        busy;
    logic        done;
    logic [31:0] cos_out;
    logic [31:0] sin_out;

    int checks = 0;
    int errors = 0;

    sincos #(.ITER(ITER)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .ang     (ang),
        .busy    (busy),
        .done    (done),
        .cos_out (cos_out),
        .sin_out (sin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout got no_finish want finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [31:0] ang;
        int          exp_cos;
        int          exp_sin;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input int got, input int exp, input int tol);
        int diff;
        diff = got - exp;
        if (diff < 0) diff = -diff;
        checks++;
        if (diff > tol) begin
            errors++;
            $display("FAIL %s got %0d (0x%08h) want %0d (0x%08h) tol %0d",
                     name, got, got, exp, exp, tol);
        end
    endtask

    // Reference: the real trigonometric value, scaled to Q8.24.
    function automatic int ref_val(input logic [31:0] a, input bit is_sin);
        real deg;
        real rad;
        real v;
        deg = $itor($signed(a)) / 16777216.0;
        rad = deg * 3.14159265358979323846 / 180.0;
        v   = is_sin ? $sin(rad) : $cos(rad);
        return $rtoi($floor(v * 16777216.0 + 0.5));
    endfunction

    // Call at #1 after a rising edge, with the DUT idle. The task returns at #1 after the done edge.
    // lat is the number of edges from the accepting edge to done, or -1 on timeout.
    task automatic convert(input logic [31:0] a, output int c, output int s, output int lat);
        start = 1'b1;
        ang   = a;
        @(posedge clk);
        #1;
        start = 1'b0;
        ang   = $urandom();
        chk("busy_after_accept", int'(busy), 1, 0);
        lat = -1;
        for (int n = 1; n <= 200 && lat < 0; n++) begin
            @(posedge clk);
            #1;
            if (done) lat = n;
        end
        c = $signed(cos_out);
        s = $signed(sin_out);
    endtask

    int c, s, lat;

    initial begin
        vecs[0] = '{32'h0000_0000, 32'sh0100_0000, 32'sh0000_0000};
        vecs[1] = '{32'h1E00_0000, 32'sh00DD_B3D7, 32'sh0080_0000};
        vecs[2] = '{32'h7800_0000, 32'shFF80_0000, 32'sh00DD_B3D7};
        vecs[3] = '{32'hA600_0000, 32'sh0000_0000, 32'shFF00_0000};
        vecs[4] = '{32'h5A00_0000, 32'sh0000_0000, 32'sh0100_0000};
        vecs[5] = '{32'h2D00_0000, 32'sh00B5_04F3, 32'sh00B5_04F3};
        vecs[6] = '{32'h8800_0000, 32'shFF80_0000, 32'shFF22_4C29};
        vecs[7] = '{32'h3C00_0000, 32'sh0080_0000, 32'sh00DD_B3D7};

        rst_n = 1'b0;
        start = 1'b0;
        ang   = '0;
        #12;
        chk("reset_busy", int'(busy), 0, 0);
        chk("reset_done", int'(done), 0, 0);
        chk("reset_cos", $signed(cos_out), 0, 0);
        chk("reset_sin", $signed(sin_out), 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known angles
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].ang, c, s, lat);
            chk($sformatf("vec%0d_latency", i), lat, int'(ITER) + 1, 0);
            chk($sformatf("vec%0d_cos", i), c, vecs[i].exp_cos, TOL);
            chk($sformatf("vec%0d_sin", i), s, vecs[i].exp_sin, TOL);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_done_width", i), int'(done), 0, 0);
            chk($sformatf("vec%0d_busy_fall", i), int'(busy), 0, 0);
        end

        // Random angles. Every 32-bit value is a legal Q8.24 angle.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = $urandom();
            convert(a, c, s, lat);
            chk($sformatf("rnd%0d_latency", i), lat, int'(ITER) + 1, 0);
            chk($sformatf("rnd%0d_cos_ang%08h", i, a), c, ref_val(a, 1'b0), TOL);
            chk($sformatf("rnd%0d_sin_ang%08h", i, a), s, ref_val(a, 1'b1), TOL);
            @(posedge clk);
            #1;
        end

        // A start pulse during RUN must be ignored. done pulses once, and the outputs hold afterwards.
        begin
            int first;
            int dcnt;
            int hc, hs;
            first = -1;
            dcnt  = 0;
            hc    = 0;
            hs    = 0;
            start = 1'b1;
            ang   = 32'h1E00_0000;
            @(posedge clk);
            #1;
            start = 1'b0;
            for (int n = 1; n <= 60; n++) begin
                @(posedge clk);
                #1;
                if (n == 10) begin
                    start = 1'b1;
                    ang   = 32'hC400_0000;
                end
                if (n == 11) start = 1'b0;
                if (done) begin
                    dcnt++;
                    if (first < 0) begin
                        first = n;
                        hc    = $signed(cos_out);
                        hs    = $signed(sin_out);
                    end
                end
                if (first > 0 && n == first + 3)
                    chk("hs_busy_stays_low", int'(busy), 0, 0);
                if (first > 0 && n == first + 6) begin
                    chk("hs_cos_hold", $signed(cos_out), hc, 0);
                    chk("hs_sin_hold", $signed(sin_out), hs, 0);
                end
            end
            chk("hs_latency", first, int'(ITER) + 1, 0);
            chk("hs_done_count", dcnt, 1, 0);
            chk("hs_cos_first_ang", hc, 32'sh00DD_B3D7, TOL);
            chk("hs_sin_first_ang", hs, 32'sh0080_0000, TOL);
        end

        // start held high: the DONE edge ignores it, the next edge accepts it. That gives one
        // conversion every ITER+2 cycles.
        begin
            int d1, d2;
            d1 = -1;
            d2 = -1;
            start = 1'b1;
            ang   = 32'h2D00_0000;
            @(posedge clk);
            #1;
            for (int n = 1; n <= 2 * int'(ITER) + 10; n++) begin
                @(posedge clk);
                #1;
                if (n == int'(ITER) + 2) start = 1'b0;
                if (done) begin
                    if (d1 < 0) d1 = n;
                    else if (d2 < 0) d2 = n;
                end
            end
            chk("b2b_first_done", d1, int'(ITER) + 1, 0);
            chk("b2b_period", d2 - d1, int'(ITER) + 2, 0);
            chk("b2b_cos", $signed(cos_out), 32'sh00B5_04F3, TOL);
            chk("b2b_busy_idle", int'(busy), 0, 0);
        end

        // Reset asserted mid-RUN clears everything at once.
        start = 1'b1;
        ang   = 32'h3C00_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", int'(busy), 0, 0);
        chk("rst_mid_done", int'(done), 0, 0);
        chk("rst_mid_cos", $signed(cos_out), 0, 0);
        chk("rst_mid_sin", $signed(sin_out), 0, 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        convert(32'h1E00_0000, c, s, lat);
        chk("post_rst_latency", lat, int'(ITER) + 1, 0);
        chk("post_rst_cos", c, 32'sh00DD_B3D7, TOL);
        chk("post_rst_sin", s, 32'sh0080_0000, TOL);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
